// File: rtl/dma_periph_port.sv
// 8237A-style DMA peripheral endpoint: DREQ/DACK handshake, strobe-edge byte transfers and EOP
// handling, with a small byte FIFO between the DMA bus and a local device stream.
module dma_periph_port #(
   parameter int unsigned DEPTH = 8,
   parameter int unsigned AW    = 3
) (
   input  logic       CLK,
   input  logic       RESET,
   input  logic       ENABLE,
   input  logic       DIR,
   input  logic [7:0] XFER_LEN,
   output logic       DREQ,
   input  logic       DACK,
   input  logic       IOR_N,
   input  logic       IOW_N,
   input  logic [7:0] DB_IN,
   output logic [7:0] DB_OUT,
   output logic       DB_OE,
   input  logic       EOP_IN_N,
   output logic       EOP_OUT_N,
   input  logic       DEV_IN_VALID,
   input  logic [7:0] DEV_IN_DATA,
   output logic       DEV_IN_READY,
   output logic       DEV_OUT_VALID,
   output logic [7:0] DEV_OUT_DATA,
   input  logic       DEV_OUT_READY,
   output logic       DONE,
   output logic       ABORTED
);

   typedef enum logic [2:0] {StIdle, StArm, StReq, StAck, StFin} state_e;

   localparam logic [AW:0] DepthCnt = (AW + 1)'(DEPTH);

   state_e        state_q, state_d;
   logic          dir_q, dir_d;
   logic [8:0]    rem_q, rem_d;
   logic          aborted_q, aborted_d;
   logic          dreq_q;
   logic          ior_q, iow_q;
   logic [7:0]    db_q;
   logic [7:0]    mem_q [DEPTH];
   logic [AW-1:0] wr_ptr_q, rd_ptr_q;
   logic [AW:0]   count_q, count_d;

   logic       full, empty, flush, xfer;
   logic       push, pop, push_en, pop_en, ready_now, ready_next;
   logic [7:0] push_data;

   assign full  = (count_q == DepthCnt);
   assign empty = (count_q == '0);
   assign flush = (state_q == StIdle) & ENABLE;

   // A transfer completes on the rising edge of the strobe that matches the latched direction
   assign xfer = (state_q == StAck) & DACK &
                 (dir_q ? (~iow_q & IOW_N) : (~ior_q & IOR_N));

   assign DEV_IN_READY  = ~dir_q & ~full & (state_q != StIdle);
   assign DEV_OUT_VALID = dir_q & ~empty;
   assign DEV_OUT_DATA  = mem_q[rd_ptr_q];

   assign push      = dir_q ? xfer : (DEV_IN_VALID & DEV_IN_READY);
   assign pop       = dir_q ? (DEV_OUT_VALID & DEV_OUT_READY) : xfer;
   assign push_en   = push & ~full & ~flush;
   assign pop_en    = pop & ~empty & ~flush;
   assign push_data = dir_q ? db_q : DEV_IN_DATA;

   always_comb begin
      count_d = count_q;
      if (flush) begin
         count_d = '0;
      end else if (push_en && !pop_en) begin
         count_d = count_q + 1'b1;
      end else if (pop_en && !push_en) begin
         count_d = count_q - 1'b1;
      end
   end

   assign ready_now  = dir_q ? ~full : ~empty;
   assign ready_next = dir_q ? (count_d != DepthCnt) : (count_d != '0);

   always_comb begin
      state_d   = state_q;
      dir_d     = dir_q;
      rem_d     = rem_q;
      aborted_d = aborted_q;
      unique case (state_q)
         StIdle: begin
            if (ENABLE) begin
               dir_d     = DIR;
               rem_d     = (XFER_LEN == 8'd0) ? 9'd256 : {1'b0, XFER_LEN};
               aborted_d = 1'b0;
               state_d   = StArm;
            end
         end
         StArm: begin
            if (ready_now) state_d = StReq;
         end
         StReq: begin
            if (DACK) state_d = StAck;
         end
         StAck: begin
            if (xfer) begin
               rem_d = rem_q - 9'd1;
               if (rem_d == 9'd0)    state_d = StFin;
               else if (!ready_next) state_d = StArm;
            end else if (!DACK) begin
               state_d = StReq;
            end
         end
         StFin: state_d = StIdle;
         default: state_d = StIdle;
      endcase
      // External EOP wins; a same-cycle transfer is already folded into rem_d
      if ((state_q == StArm || state_q == StReq || state_q == StAck) && !EOP_IN_N) begin
         state_d = StFin;
         if (rem_d != 9'd0) aborted_d = 1'b1;
      end
   end

   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         state_q   <= StIdle;
         dir_q     <= 1'b0;
         rem_q     <= '0;
         aborted_q <= 1'b0;
         dreq_q    <= 1'b0;
         ior_q     <= 1'b1;
         iow_q     <= 1'b1;
         db_q      <= '0;
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         count_q   <= '0;
         for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      end else begin
         state_q   <= state_d;
         dir_q     <= dir_d;
         rem_q     <= rem_d;
         aborted_q <= aborted_d;
         dreq_q    <= (state_d == StReq) || (state_d == StAck);
         ior_q     <= IOR_N;
         iow_q     <= IOW_N;
         db_q      <= DB_IN;
         count_q   <= count_d;
         if (flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
         end else begin
            if (push_en) begin
               mem_q[wr_ptr_q] <= push_data;
               wr_ptr_q        <= wr_ptr_q + 1'b1;
            end
            if (pop_en) rd_ptr_q <= rd_ptr_q + 1'b1;
         end
      end
   end

   assign DREQ      = dreq_q;
   assign DB_OUT    = mem_q[rd_ptr_q];
   assign DB_OE     = (state_q == StAck) & ~dir_q & DACK & ~IOR_N;
   assign EOP_OUT_N = ~((state_q == StAck) & DACK & (rem_q == 9'd1));
   assign DONE      = (state_q == StFin);
   assign ABORTED   = aborted_q;

endmodule

// File: tb/tb_dma_periph_port.sv
// Directed bench for dma_periph_port: a per-cycle vector table for a short read block, then
// hand-written sequences for abort, EOP/terminal-count overlap, FIFO-full stall, 256-byte and reset.
module tb_dma_periph_port;

   logic       CLK, RESET, ENABLE, DIR, DACK, IOR_N, IOW_N, EOP_IN_N;
   logic [7:0] XFER_LEN, DB_IN, DEV_IN_DATA;
   logic       DEV_IN_VALID, DEV_OUT_READY;
   logic       DREQ, DB_OE, EOP_OUT_N, DEV_IN_READY, DEV_OUT_VALID, DONE, ABORTED;
   logic [7:0] DB_OUT, DEV_OUT_DATA;

   int checks = 0;
   int errors = 0;
   int done_cnt = 0;
   logic [7:0] rx_q [$];

   dma_periph_port #(.DEPTH(8), .AW(3)) dut (
      .CLK(CLK), .RESET(RESET), .ENABLE(ENABLE), .DIR(DIR), .XFER_LEN(XFER_LEN),
      .DREQ(DREQ), .DACK(DACK), .IOR_N(IOR_N), .IOW_N(IOW_N), .DB_IN(DB_IN),
      .DB_OUT(DB_OUT), .DB_OE(DB_OE), .EOP_IN_N(EOP_IN_N), .EOP_OUT_N(EOP_OUT_N),
      .DEV_IN_VALID(DEV_IN_VALID), .DEV_IN_DATA(DEV_IN_DATA), .DEV_IN_READY(DEV_IN_READY),
      .DEV_OUT_VALID(DEV_OUT_VALID), .DEV_OUT_DATA(DEV_OUT_DATA),
      .DEV_OUT_READY(DEV_OUT_READY), .DONE(DONE), .ABORTED(ABORTED)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   always @(negedge CLK) begin
      if (DONE === 1'b1) done_cnt++;
      if (DEV_OUT_VALID === 1'b1 && DEV_OUT_READY === 1'b1) rx_q.push_back(DEV_OUT_DATA);
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got no end of test, required finish");
      $fatal(1);
   end

   typedef struct {
      logic       en;
      logic       dir;
      logic [7:0] len;
      logic       dack;
      logic       ior_n;
      logic       inv;
      logic [7:0] ind;
      logic       dreq;
      logic       oe;
      logic [7:0] dbo;
      logic       eopo;
      logic       done;
      logic       inrdy;
   } vec_t;

   vec_t vecs [15];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h required %0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   task automatic wait_dreq(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 64; i++) begin
         if (DREQ === 1'b1) begin
            ok = 1'b1;
            break;
         end
         step();
      end
      if (!ok) begin
         checks++;
         errors++;
         $display("FAIL dreq_timeout: got DREQ=0 for 64 cycles, required 1");
      end
   endtask

   task automatic arm(input logic dir, input logic [7:0] len);
      ENABLE = 1'b1; DIR = dir; XFER_LEN = len;
      step();
      ENABLE = 1'b0;
   endtask

   task automatic push_byte(input logic [7:0] b);
      DEV_IN_VALID = 1'b1; DEV_IN_DATA = b;
      #1;
      chk("dev_in_ready", 32'(DEV_IN_READY), 32'd1);
      step();
      DEV_IN_VALID = 1'b0;
   endtask

   task automatic dma_read(input bit eop_on_xfer, output logic [7:0] d, output bit eop_low,
                           output bit oe_ok);
      bit ok;
      d = '0; eop_low = 1'b0; oe_ok = 1'b0;
      wait_dreq(ok);
      if (!ok) return;
      DACK = 1'b1;
      step();
      IOR_N = 1'b0;
      #1;
      d = DB_OUT; eop_low = (EOP_OUT_N === 1'b0); oe_ok = (DB_OE === 1'b1);
      step();
      IOR_N = 1'b1; EOP_IN_N = ~eop_on_xfer;
      #1;
      oe_ok = oe_ok && (DB_OE === 1'b0);
      step();
      DACK = 1'b0; EOP_IN_N = 1'b1;
      step();
   endtask

   task automatic dma_write(input logic [7:0] d, output bit eop_low);
      bit ok;
      eop_low = 1'b0;
      wait_dreq(ok);
      if (!ok) return;
      DACK = 1'b1;
      step();
      IOW_N = 1'b0; DB_IN = d;
      #1;
      eop_low = (EOP_OUT_N === 1'b0);
      step();
      IOW_N = 1'b1;
      step();
      DACK = 1'b0;
      step();
   endtask

   initial begin
      logic [7:0] d;
      bit         e, oe;
      int         base, eop_cnt, eop_idx, n;

      // en dir len dack ior_n inv ind | dreq oe dbo eopo done inrdy
      vecs[0]  = '{1'b1, 1'b0, 8'd3, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0};
      vecs[1]  = '{1'b0, 1'b0, 8'd3, 1'b0, 1'b1, 1'b1, 8'hA1, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1};
      vecs[2]  = '{1'b0, 1'b0, 8'd3, 1'b0, 1'b1, 1'b1, 8'hB2, 1'b0, 1'b0, 8'hA1, 1'b1, 1'b0, 1'b1};
      vecs[3]  = '{1'b0, 1'b0, 8'd3, 1'b0, 1'b1, 1'b1, 8'hC3, 1'b1, 1'b0, 8'hA1, 1'b1, 1'b0, 1'b1};
      vecs[4]  = '{1'b0, 1'b0, 8'd3, 1'b1, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 8'hA1, 1'b1, 1'b0, 1'b1};
      vecs[5]  = '{1'b0, 1'b0, 8'd3, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 8'hA1, 1'b1, 1'b0, 1'b1};
      vecs[6]  = '{1'b0, 1'b0, 8'd3, 1'b1, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 8'hA1, 1'b1, 1'b0, 1'b1};
      vecs[7]  = '{1'b0, 1'b0, 8'd3, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 8'hB2, 1'b1, 1'b0, 1'b1};
      vecs[8]  = '{1'b0, 1'b0, 8'd3, 1'b1, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 8'hB2, 1'b1, 1'b0, 1'b1};
      vecs[9]  = '{1'b0, 1'b0, 8'd3, 1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 8'hC3, 1'b1, 1'b0, 1'b1};
      vecs[10] = '{1'b0, 1'b0, 8'd3, 1'b1, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 8'hC3, 1'b1, 1'b0, 1'b1};
      vecs[11] = '{1'b0, 1'b0, 8'd3, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 8'hC3, 1'b0, 1'b0, 1'b1};
      vecs[12] = '{1'b0, 1'b0, 8'd3, 1'b1, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 8'hC3, 1'b0, 1'b0, 1'b1};
      vecs[13] = '{1'b0, 1'b0, 8'd3, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1};
      vecs[14] = '{1'b0, 1'b0, 8'd3, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0};

      RESET = 1'b0; ENABLE = 1'b0; DIR = 1'b0; XFER_LEN = 8'd0; DACK = 1'b0;
      IOR_N = 1'b1; IOW_N = 1'b1; DB_IN = 8'h00; EOP_IN_N = 1'b1;
      DEV_IN_VALID = 1'b0; DEV_IN_DATA = 8'h00; DEV_OUT_READY = 1'b0;
      #1;
      chk("reset_outputs",
          32'({DREQ, DB_OE, DB_OUT, EOP_OUT_N, DONE, ABORTED, DEV_IN_READY, DEV_OUT_VALID}),
          32'({1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0}));
      step();
      step();
      RESET = 1'b1;
      step();

      // DIR=0, 3-byte block, one DACK drop before the last transfer
      for (int i = 0; i < 15; i++) begin
         ENABLE = vecs[i].en; DIR = vecs[i].dir; XFER_LEN = vecs[i].len;
         DACK = vecs[i].dack; IOR_N = vecs[i].ior_n;
         DEV_IN_VALID = vecs[i].inv; DEV_IN_DATA = vecs[i].ind;
         #1;
         chk($sformatf("vec%0d", i),
             32'({DREQ, DB_OE, DB_OUT, EOP_OUT_N, DONE, ABORTED, DEV_IN_READY, DEV_OUT_VALID}),
             32'({vecs[i].dreq, vecs[i].oe, vecs[i].dbo, vecs[i].eopo, vecs[i].done, 1'b0,
                  vecs[i].inrdy, 1'b0}));
         step();
      end
      DACK = 1'b0; IOR_N = 1'b1; DEV_IN_VALID = 1'b0;
      chk("table_done_count", 32'(done_cnt), 32'd1);

      // DIR=0, 5-byte block aborted by EOP_IN_N after two transfers
      arm(1'b0, 8'd5);
      push_byte(8'h31);
      push_byte(8'h32);
      push_byte(8'h33);
      dma_read(1'b0, d, e, oe);
      chk("abort_rd0", 32'(d), 32'h31);
      chk("abort_rd0_oe", 32'(oe), 32'd1);
      dma_read(1'b0, d, e, oe);
      chk("abort_rd1", 32'(d), 32'h32);
      base = done_cnt;
      EOP_IN_N = 1'b0;
      step();
      EOP_IN_N = 1'b1;
      #1;
      chk("abort_fin", 32'({DONE, DREQ, ABORTED}), 32'({1'b1, 1'b0, 1'b1}));
      step();
      chk("abort_sticky", 32'({DONE, ABORTED}), 32'({1'b0, 1'b1}));
      chk("abort_done_once", 32'(done_cnt - base), 32'd1);

      // Final transfer coinciding with EOP_IN_N: counted, not aborted
      arm(1'b0, 8'd1);
      chk("arm_clears_aborted", 32'(ABORTED), 32'd0);
      push_byte(8'h5A);
      base = done_cnt;
      dma_read(1'b1, d, e, oe);
      chk("tc_eop_data", 32'(d), 32'h5A);
      chk("tc_eop_out_low", 32'(e), 32'd1);
      chk("tc_eop_done", 32'(done_cnt - base), 32'd1);
      chk("tc_eop_not_aborted", 32'(ABORTED), 32'd0);

      // DIR=1, 10 bytes with the local sink stalled until the FIFO fills
      rx_q.delete();
      DEV_OUT_READY = 1'b0;
      base = done_cnt;
      arm(1'b1, 8'd10);
      for (int i = 0; i < 8; i++) dma_write(8'(8'h10 + i), e);
      chk("full_dreq_low", 32'(DREQ), 32'd0);
      chk("full_out_head", 32'({DEV_OUT_VALID, DEV_OUT_DATA}), 32'({1'b1, 8'h10}));
      repeat (4) step();
      chk("full_dreq_stays_low", 32'(DREQ), 32'd0);
      DEV_OUT_READY = 1'b1;
      step();
      DEV_OUT_READY = 1'b0;
      n = 0;
      while (DREQ !== 1'b1 && n < 8) begin
         step();
         n++;
      end
      chk("drain_reraises_dreq", 32'(DREQ), 32'd1);
      DEV_OUT_READY = 1'b1;
      dma_write(8'h18, e);
      dma_write(8'h19, e);
      chk("w10_eop_last", 32'(e), 32'd1);
      repeat (12) step();
      chk("w10_rx_count", 32'(rx_q.size()), 32'd10);
      for (int i = 0; i < 10 && i < rx_q.size(); i++)
         chk($sformatf("w10_rx%0d", i), 32'(rx_q[i]), 32'(8'h10 + i));
      chk("w10_done", 32'(done_cnt - base), 32'd1);

      // XFER_LEN=0 means 256 transfers; EOP_OUT_N only on the last one
      rx_q.delete();
      eop_cnt = 0;
      eop_idx = -1;
      base = done_cnt;
      arm(1'b1, 8'd0);
      for (int i = 0; i < 256; i++) begin
         if (i == 255) chk("b256_no_early_done", 32'(done_cnt - base), 32'd0);
         dma_write(8'(i), e);
         if (e) begin
            eop_cnt++;
            eop_idx = i;
         end
      end
      repeat (4) step();
      chk("b256_eop_count", 32'(eop_cnt), 32'd1);
      chk("b256_eop_index", 32'(eop_idx), 32'd255);
      chk("b256_done", 32'(done_cnt - base), 32'd1);
      chk("b256_rx_count", 32'(rx_q.size()), 32'd256);
      if (rx_q.size() == 256) chk("b256_rx_last", 32'(rx_q[255]), 32'hFF);
      DEV_OUT_READY = 1'b0;

      // Reset asserted mid-ACK with the read strobe low
      arm(1'b0, 8'd1);
      push_byte(8'h77);
      wait_dreq(e);
      DACK = 1'b1;
      step();
      IOR_N = 1'b0;
      #1;
      chk("pre_reset_ack", 32'({DB_OE, EOP_OUT_N, DB_OUT}), 32'({1'b1, 1'b0, 8'h77}));
      RESET = 1'b0;
      #1;
      chk("reset_mid_ack",
          32'({DREQ, DB_OE, EOP_OUT_N, DONE, DEV_IN_READY, DB_OUT}),
          32'({1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00}));
      step();
      RESET = 1'b1; DACK = 1'b0; IOR_N = 1'b1;
      n = 0;
      for (int i = 0; i < 5; i++) begin
         step();
         if (DREQ !== 1'b0) n++;
      end
      chk("dreq_low_after_reset", 32'(n), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/dma_periph_port.md
Name: dma_periph_port

Overview:
Single-channel I/O peripheral endpoint for the 8237A DMA handshake. It faces the DMA controller: it raises DREQ, answers DACK, sources or sinks DB on IOR_N/IOW_N strobes, and terminates blocks with EOP. Internally it buffers bytes in a small FIFO between the DMA side and a local device stream. One instance connects to one DREQ/DACK bit pair of dma_if.

Parameters:
DEPTH, 8, FIFO depth in bytes; must be a power of 2, at least 2.
AW, 3, FIFO pointer width, equal to log2(DEPTH).

Ports:
CLK  input  1  system clock, shared with the DMA controller
RESET  input  1  asynchronous reset, active-low
ENABLE  input  1  arms a block; sampled in IDLE
DIR  input  1  0 = device-to-memory (DMA reads I/O via IOR_N); 1 = memory-to-device (IOW_N); sampled on leaving IDLE
XFER_LEN  input  8  block length in bytes; 0 encodes 256; sampled on leaving IDLE
DREQ  output  1  DMA request, active-high
DACK  input  1  DMA acknowledge, active-high
IOR_N  input  1  I/O read strobe from the DMA controller
IOW_N  input  1  I/O write strobe from the DMA controller
DB_IN  input  8  data bus in
DB_OUT  output  8  data bus out
DB_OE  output  1  data bus output enable
EOP_IN_N  input  1  terminal count / abort from the DMA controller, active-low
EOP_OUT_N  output  1  peripheral-driven end of process, active-low, open-drain style (only ever driven 0)
DEV_IN_VALID  input  1  local byte available (DIR=0)
DEV_IN_DATA  input  8  local byte
DEV_IN_READY  output  1  FIFO accepts the local byte
DEV_OUT_VALID  output  1  FIFO byte available to local sink (DIR=1)
DEV_OUT_DATA  output  8  FIFO head byte
DEV_OUT_READY  input  1  local sink takes the byte
DONE  output  1  one-cycle pulse when the block ends
ABORTED  output  1  sticky flag: the block ended by EOP_IN_N before the count expired; cleared on the next arm

Behaviour:
- Reset values: DREQ=0, DB_OE=0, DB_OUT=0, EOP_OUT_N=1, DEV_IN_READY=0, DEV_OUT_VALID=0, DONE=0, ABORTED=0. FIFO is empty, counter=0, state=IDLE. Reset asserted mid-block returns everything to these values immediately and discards FIFO contents.
- Strobe edge detection: IOR_N and IOW_N are registered once. A strobe completes on the cycle where the registered value is 0, the current value is 1, and DACK=1. This cycle is called XFER.
- FSM states: IDLE, ARM, REQ, ACK, FIN.
- IDLE: on ENABLE=1, latch DIR and load rem=XFER_LEN (0 loads 256 in a 9-bit counter). Clear ABORTED and go to ARM.
- ARM: local side active. The FIFO flushes only in IDLE. Go to REQ when the FIFO is ready, which means: DIR=0 and count>=1, or DIR=1 and count<=DEPTH-1.
- REQ: DREQ=1 (registered). Go to ACK when DACK=1.
- ACK: DREQ stays 1 while DACK=1.
  - DIR=0: DB_OE = DACK & ~IOR_N (combinational). DB_OUT = FIFO head. Pop on XFER.
  - DIR=1: DB_OE=0. Push DB_IN on XFER. DB_IN is captured from the registered bus on the low-to-high strobe edge.
  - On XFER: rem decrements. If the new rem is 0, go to FIN. Otherwise, if the FIFO is no longer ready, go to ARM with DREQ=0 on the next cycle. Otherwise stay in REQ or ACK, and DREQ stays 1 (demand transfers are allowed).
  - DACK falling without XFER: return to REQ.
- EOP_OUT_N = 0 while in ACK, DACK=1 and rem==1, for the whole final transfer. It is 1 at all other times.
- EOP_IN_N=0 in ARM, REQ or ACK: go to FIN the next cycle. Set ABORTED=1 if rem>1, or if rem==1 and no XFER happened in that cycle. If XFER and EOP_IN_N occur in the same cycle, the transfer is counted first.
- FIN: DREQ=0 and DONE=1 for one cycle, then IDLE. FIFO data is kept so a DIR=1 local drain can finish.
- Local side (any state except reset):
  - DEV_IN_READY = (DIR=0) & ~full & (state != IDLE).
  - DEV_OUT_VALID = ~empty & (latched DIR=1).
  - A push and a pop in the same cycle are both honoured, and the count is unchanged.
- FIFO rules: pointers wrap modulo DEPTH. Count is AW+1 bits. Full means count==DEPTH. A push when full or a pop when empty is ignored, and the bus side can never cause it because of the REQ gating.

Test Plan:
- Reset mid-ACK (DACK=1, IOR_N=0): assert RESET=0 -> DREQ=0, DB_OE=0 and EOP_OUT_N=1 immediately; DREQ stays 0 after release until re-armed.
- DIR=0, XFER_LEN=3, push 0xA1,0xB2,0xC3 locally -> DREQ rises; three IOR_N pulses under DACK drive DB_OUT=A1,B2,C3 with DB_OE only while IOR_N=0; EOP_OUT_N=0 during the 3rd DACK only; DONE pulses once; ABORTED=0.
- DIR=1, DEPTH=8, XFER_LEN=10, DEV_OUT_READY=0 -> after 8 IOW_N writes DREQ drops (full); pulsing DEV_OUT_READY once re-raises DREQ; 10 bytes are received in order, rem reaches 0 and DONE pulses.
- DIR=0, XFER_LEN=5, EOP_IN_N pulsed low after 2 transfers -> FIN next cycle, DREQ=0, DONE=1, ABORTED=1.
- XFER_LEN=0 (256 bytes), DIR=1 with continuous local drain -> exactly 256 XFERs; EOP_OUT_N low on the 256th only.
- Final XFER coinciding with EOP_IN_N=0 -> DONE=1 and ABORTED=0.
